// File: rtl/scroll_scheduler.sv
// Scroll sequencer for the layer stack: 1 ms tick, LFSR-driven top-layer maps, init fill and per-request scroll.
// A request in idle gives layer_start two cycles later. Requests made while busy are held one deep.
module scroll_scheduler #(
  parameter int          CLKS_PER_MS  = 65000,
  parameter int          SCROLL_TICKS = 150,
  parameter int          NUM_LAYERS   = 5,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        module_en,
  input  logic        scroll_req,
  output logic        one_ms_tick,
  output logic        layer_start,
  output logic        layer_load,
  output logic [6:0]  new_layer_map,
  output logic [6:0]  new_block_type,
  output logic        busy,
  output logic [15:0] scroll_count
);

  localparam int TW = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam int WW = (SCROLL_TICKS > 1) ? $clog2(SCROLL_TICKS) : 1;
  localparam int IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  localparam logic [TW-1:0] TICK_MAX = TW'(CLKS_PER_MS - 1);
  localparam logic [WW-1:0] WAIT_MAX = WW'(SCROLL_TICKS - 1);
  localparam logic [IW-1:0] INIT_MAX = IW'(NUM_LAYERS - 1);

  localparam logic [2:0] S_INIT   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_GEN    = 3'd2;
  localparam logic [2:0] S_START  = 3'd3;
  localparam logic [2:0] S_WAIT   = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic          pending_q, pending_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic          settle_q, settle_d;
  logic [6:0]    map_q, map_d;
  logic [6:0]    blk_q, blk_d;
  logic          load_q, load_d;
  logic          busy_q, busy_d;
  logic [15:0]   count_q, count_d;

  logic        tick;
  logic        gen;
  logic [15:0] lfsr_nxt;
  logic [6:0]  map_nxt;

  assign tick     = module_en && (tick_cnt_q == TICK_MAX);
  assign lfsr_nxt = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  // An all-zero map would leave the layer empty, so substitute a single centre block.
  assign map_nxt  = (lfsr_nxt[6:0] == 7'd0) ? 7'b0001000 : lfsr_nxt[6:0];

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    lfsr_d     = lfsr_q;
    pending_d  = pending_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    settle_d   = settle_q;
    map_d      = map_q;
    blk_d      = blk_q;
    load_d     = load_q;
    busy_d     = busy_q;
    count_d    = count_q;
    gen        = 1'b0;

    if (module_en) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
      load_d     = 1'b0;
      if (scroll_req && busy_q) begin
        pending_d = 1'b1;
      end

      case (state_q)
        S_INIT: begin
          gen    = 1'b1;
          load_d = 1'b1;
          if (init_cnt_q == INIT_MAX) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            init_cnt_d = init_cnt_q + 1'b1;
          end
        end
        S_IDLE: begin
          if (scroll_req || pending_q) begin
            state_d   = S_GEN;
            busy_d    = 1'b1;
            pending_d = 1'b0;
          end
        end
        S_GEN: begin
          gen     = 1'b1;
          state_d = S_START;
        end
        S_START: begin
          wait_cnt_d = '0;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (tick) begin
            if (wait_cnt_q == WAIT_MAX) begin
              state_d  = S_SETTLE;
              settle_d = 1'b0;
            end else begin
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          // Two cycles let every layer latch the map before the next request is taken.
          if (settle_q) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            count_d = (count_q != 16'hFFFF) ? count_q + 16'd1 : count_q;
          end else begin
            settle_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      endcase

      if (gen) begin
        lfsr_d = lfsr_nxt;
        map_d  = map_nxt;
        blk_d  = lfsr_nxt[13:7] & map_nxt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      tick_cnt_q <= '0;
      lfsr_q     <= LFSR_SEED;
      pending_q  <= 1'b0;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
      settle_q   <= 1'b0;
      map_q      <= '0;
      blk_q      <= '0;
      load_q     <= 1'b0;
      busy_q     <= 1'b1;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      lfsr_q     <= lfsr_d;
      pending_q  <= pending_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
      settle_q   <= settle_d;
      map_q      <= map_d;
      blk_q      <= blk_d;
      load_q     <= load_d;
      busy_q     <= busy_d;
      count_q    <= count_d;
    end
  end

  assign one_ms_tick    = tick;
  assign layer_start    = module_en && (state_q == S_START);
  assign layer_load     = load_q;
  assign new_layer_map  = map_q;
  assign new_block_type = blk_q;
  assign busy           = busy_q;
  assign scroll_count   = count_q;

endmodule

// File: tb/tb_scroll_scheduler.sv
// Bench for scroll_scheduler: LFSR/map model, tick phase model, scroll timing, pending requests, async reset.
// A second instance uses a seed whose first step yields an all-zero low map.
module tb_scroll_scheduler;

  localparam int          CLK   = 4;
  localparam int          ST    = 150;
  localparam int          NL    = 5;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam logic [15:0] ZSEED = 16'h1600;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        module_en = 1'b1;
  logic        scroll_req = 1'b0;
  logic        one_ms_tick, layer_start, layer_load, busy;
  logic [6:0]  new_layer_map, new_block_type;
  logic [15:0] scroll_count;
  logic        z_tick, z_start, z_load, z_busy;
  logic [6:0]  z_map, z_blk;
  logic [15:0] z_count;

  int          checks = 0;
  int          failures = 0;
  int          ph = 0;
  logic [15:0] lm, zl;

  always #5 clk = ~clk;

  scroll_scheduler #(.CLKS_PER_MS(CLK), .SCROLL_TICKS(ST), .NUM_LAYERS(NL), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .module_en(module_en), .scroll_req(scroll_req),
    .one_ms_tick(one_ms_tick), .layer_start(layer_start), .layer_load(layer_load),
    .new_layer_map(new_layer_map), .new_block_type(new_block_type),
    .busy(busy), .scroll_count(scroll_count)
  );

  scroll_scheduler #(.CLKS_PER_MS(CLK), .SCROLL_TICKS(ST), .NUM_LAYERS(2), .LFSR_SEED(ZSEED)) dut_z (
    .clk(clk), .rst(rst), .module_en(module_en), .scroll_req(1'b0),
    .one_ms_tick(z_tick), .layer_start(z_start), .layer_load(z_load),
    .new_layer_map(z_map), .new_block_type(z_blk),
    .busy(z_busy), .scroll_count(z_count)
  );

  function automatic logic [15:0] lstep(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [6:0] emap(input logic [15:0] n);
    return (n[6:0] == 7'd0) ? 7'b0001000 : n[6:0];
  endfunction

  function automatic logic [6:0] eblk(input logic [15:0] n);
    return n[13:7] & emap(n);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the tick phase only moves on cycles that were enabled.
  task automatic cyc();
    logic en;
    en = module_en;
    @(posedge clk);
    #1;
    if (en) ph = (ph + 1) % CLK;
  endtask

  task automatic load_burst(input string tag);
    int n = 0;
    int nz = 0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      if (layer_load) begin
        n++;
        lm = lstep(lm);
        check({tag, "_map"}, 32'(new_layer_map), 32'(emap(lm)));
        check({tag, "_blk"}, 32'(new_block_type), 32'(eblk(lm)));
        check({tag, "_map_nonzero"}, 32'(new_layer_map != 7'd0), 32'd1);
      end
      if (z_load) begin
        nz++;
        zl = lstep(zl);
        check({tag, "_zmap"}, 32'(z_map), 32'(emap(zl)));
        check({tag, "_zblk"}, 32'(z_blk), 32'(eblk(zl)));
        check({tag, "_zblk_subset"}, 32'(z_blk & ~z_map), 32'd0);
      end
    end
    check({tag, "_load_cycles"}, n, NL);
    check({tag, "_zload_cycles"}, nz, 2);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_count_after"}, 32'(scroll_count), 32'd0);
  endtask

  initial begin
    int rel, counted, tfall, fall, stable_bad, extra_start, starts, quiet, r1, r2, r3, w;

    rst = 1'b1;
    module_en = 1'b1;
    scroll_req = 1'b0;
    repeat (2) cyc();
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_load", 32'(layer_load), 32'd0);
    check("rst_start", 32'(layer_start), 32'd0);
    check("rst_tick", 32'(one_ms_tick), 32'd0);
    check("rst_map", 32'(new_layer_map), 32'd0);
    check("rst_blk", 32'(new_block_type), 32'd0);
    check("rst_count", 32'(scroll_count), 32'd0);

    rst = 1'b0;
    ph = 0;
    lm = SEED;
    zl = ZSEED;
    load_burst("init");

    for (int i = 0; i < 12; i++) begin
      cyc();
      check("tick_run", 32'(one_ms_tick), 32'(module_en && ph == CLK - 1));
    end
    module_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("tick_frozen", 32'(one_ms_tick), 32'd0);
    end
    module_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc();
      check("tick_resume", 32'(one_ms_tick), 32'(module_en && ph == CLK - 1));
    end

    // Single scroll: start latency, map hold and busy fall time from the tick phase.
    scroll_req = 1'b1;
    cyc();
    scroll_req = 1'b0;
    check("lat_n1_start", 32'(layer_start), 32'd0);
    check("lat_n1_busy", 32'(busy), 32'd1);
    cyc();
    check("lat_n2_start", 32'(layer_start), 32'd1);
    lm = lstep(lm);
    check("scroll_map", 32'(new_layer_map), 32'(emap(lm)));
    check("scroll_blk", 32'(new_block_type), 32'(eblk(lm)));
    rel = 2;
    counted = 0;
    tfall = -1;
    fall = -1;
    stable_bad = 0;
    extra_start = 0;
    for (int i = 0; i < 800 && fall < 0; i++) begin
      cyc();
      rel++;
      if (rel >= 3 && module_en && ph == CLK - 1 && counted < ST) begin
        counted++;
        if (counted == ST) tfall = rel + 3;
      end
      if (new_layer_map !== emap(lm) || new_block_type !== eblk(lm)) stable_bad++;
      if (layer_start) extra_start++;
      if (!busy) fall = rel;
    end
    check("busy_fall_cycle", fall, tfall);
    check("busy_fall_window", 32'(fall >= 602 && fall <= 605), 32'd1);
    check("map_stable", stable_bad, 0);
    check("single_start_pulse", extra_start, 0);
    check("count_one", 32'(scroll_count), 32'd1);

    // Three requests while busy collapse into one extra scroll.
    r1 = int'($urandom_range(3, 100));
    r2 = r1 + int'($urandom_range(1, 200));
    r3 = r2 + int'($urandom_range(1, 200));
    scroll_req = 1'b1;
    cyc();
    scroll_req = 1'b0;
    rel = 1;
    starts = 0;
    quiet = 0;
    for (int i = 0; i < 2500 && !(starts >= 2 && quiet >= 20); i++) begin
      scroll_req = (rel == r1 || rel == r2 || rel == r3);
      cyc();
      rel++;
      if (layer_start) begin
        starts++;
        lm = lstep(lm);
        check("pend_map", 32'(new_layer_map), 32'(emap(lm)));
        check("pend_blk", 32'(new_block_type), 32'(eblk(lm)));
      end
      quiet = busy ? 0 : quiet + 1;
    end
    scroll_req = 1'b0;
    check("pend_starts", starts, 2);
    check("pend_count", 32'(scroll_count), 32'd3);
    check("pend_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of the wait phase.
    scroll_req = 1'b1;
    cyc();
    scroll_req = 1'b0;
    w = int'($urandom_range(20, 400));
    repeat (w) cyc();
    check("wait_busy", 32'(busy), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy), 32'd1);
    check("arst_count", 32'(scroll_count), 32'd0);
    check("arst_start", 32'(layer_start), 32'd0);
    check("arst_load", 32'(layer_load), 32'd0);
    check("arst_map", 32'(new_layer_map), 32'd0);
    check("arst_blk", 32'(new_block_type), 32'd0);
    check("arst_tick", 32'(one_ms_tick), 32'd0);
    repeat (2) cyc();
    rst = 1'b0;
    ph = 0;
    lm = SEED;
    zl = ZSEED;
    load_burst("reinit");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
